dual_ram_be: RTL and testbench
==============================

# dual_ram_be

Parametrised successor to the core's two-read/one-write RAM. One instruction fetch read port plus one load/store port with per-byte write strobes. Both reads are synchronous with a `valid` qualifier and configurable 1- or 2-cycle latency. Sits between the pipeline's IF/MEM stages and the on-chip instruction/data memory, and is the drop-in memory for all RISC-V core variants.

## Interface
Parameters:
- `DW`, 32, data width in bits; must be a multiple of 8.
- `DEPTH`, 65536, words; must be a power of two.
- `RD_LAT`, 1, read latency in cycles; legal values are 1 or 2.
- `AW`, `$clog2(DEPTH)`, word-address width. Derived; do not override.

Ports:
- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `ir_req_i`  in  1  instruction read request.
- `ir_addr_i`  in  AW  instruction word address.
- `ir_data_o`  out  DW  instruction read data.
- `ir_valid_o`  out  1  instruction data valid, one-cycle pulse per request.
- `d_req_i`  in  1  data-port request.
- `d_we_i`  in  1  1 = write, 0 = read; sampled with `d_req_i`.
- `d_be_i`  in  DW/8  byte write enables; bit i covers bits [8i+7:8i].
- `d_addr_i`  in  AW  data word address.
- `d_wdata_i`  in  DW  write data.
- `d_rdata_o`  out  DW  data read data.
- `d_valid_o`  out  1  data read valid pulse. Writes never assert it.

## Operation
- The array is `DEPTH`×`DW` and is not reset; initial contents are X or come from a load file.
- **Write.** When `d_req_i & d_we_i` at an edge, write each byte whose `d_be_i` bit is 1. Other bytes are unchanged. `d_be_i` = 0 is a legal no-op.
- **Read.** When `ir_req_i` (or `d_req_i & ~d_we_i`) at edge N, sample the array at edge N. Data and valid appear after edge N+RD_LAT−1, i.e. visible RD_LAT cycles after the request cycle.
- **Hold.** Data outputs hold their last read value while no new read completes. Valid outputs are 0 in those cycles.
- Back-to-back requests are accepted every cycle, with no stall and no backpressure.
- **Same-address collision.** A data write and an instruction read to the same address at the same edge are governed by Configuration.
- **Address wrap.** Addresses are modulo DEPTH by construction; no error.
- **Reset (asserted at any time).** `ir_data_o`, `d_rdata_o` = 0 and `ir_valid_o`, `d_valid_o` = 0 immediately. In-flight reads are discarded. An array write at the edge coincident with reset assertion is not guaranteed.

## Timing
- RD_LAT=1: request at edge N → valid high during cycle N..N+1 (registered after edge N).
- RD_LAT=2: request at edge N → valid high after edge N+1. The extra stage is a plain pipeline register.
- Write is visible to reads sampled at edge N+1 onward.
- With RD_LAT=2, a write at edge N+1 does not alter a read sampled at edge N.
- All outputs are registered; there are no combinational input→output paths.

## Configuration
- `DUAL_RAM_FWD_EN` defined: an instruction read colliding with a same-address data write at the same edge returns the merged word. Enabled bytes come from `d_wdata_i`; the rest come from the array (write-first).
- Not defined: a colliding read returns the pre-write word (read-first). This is the default and is cheaper for FPGA block-RAM inference.

## Structure
- Package `dual_ram_pkg` holds:
  - the `RD_LAT` legal-value constants,
  - a `be_merge(old, new, be)` function shared by the write path and forwarding,
  - elaboration checks (DW%8, power-of-two DEPTH).
- Sub-module `ram_rd_pipe` is one output stage (data + valid, async reset, hold-on-idle). It is instantiated once per port per latency stage.

## Test plan
- Write 0xDEADBEEF to addr 5 with be=4'hF; read addr 5 on both ports → both return 0xDEADBEEF with valid exactly RD_LAT cycles later, and valid is 1 for one cycle only.
- Partial write: addr 7 holds 0x11223344; write 0xAABBCCDD with be=4'b0101 → read returns 0x11BB33DD.
- Collision: addr 9 holds 0; same edge, d write 0x12345678 be=F and ir read addr 9 → ir_data_o = 0x12345678 with `DUAL_RAM_FWD_EN`, 0 without. A read on the next cycle returns 0x12345678 in both builds.
- Streaming: ir reads of addrs 0..15 on consecutive cycles → 16 consecutive valid pulses with data in order; after `ir_req_i` drops, ir_data_o holds word 15 and ir_valid_o = 0.
- Reset mid-read at RD_LAT=2: assert rst_n=0 one cycle after a request → outputs are 0 asynchronously, no valid pulse after release, and array contents written earlier are retained.
- Wrap: write addr DEPTH−1 and read it back → correct data; d_valid_o never asserts for any write.

Source files
------------

// File: rtl/dual_ram_pkg.sv
// Shared constants and helpers for the dual-port byte-enable RAM.
// Parameter legality checks live here so every instantiating module applies the same rules.
package dual_ram_pkg;

  // Legal read-latency values
  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 2;

  // Widest data word be_merge can handle; callers cast in and out of this width
  localparam int unsigned BE_MAX_DW = 1024;
  localparam int unsigned BE_MAX_BW = BE_MAX_DW / 8;

  // Replace the bytes of old_w selected by be with the matching bytes of new_w
  function automatic logic [BE_MAX_DW-1:0] be_merge(input logic [BE_MAX_DW-1:0] old_w,
                                                    input logic [BE_MAX_DW-1:0] new_w,
                                                    input logic [BE_MAX_BW-1:0] be);
    logic [BE_MAX_DW-1:0] res;
    res = old_w;
    for (int unsigned i = 0; i < BE_MAX_BW; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_w[8*i +: 8];
      end
    end
    return res;
  endfunction

  // Data width must be a non-zero whole number of bytes within be_merge range
  function automatic bit dw_legal(input int unsigned dw);
    return (dw != 0) && ((dw % 8) == 0) && (dw <= BE_MAX_DW);
  endfunction

  // Depth must be a power of two of at least 2 so the address width is non-zero
  function automatic bit depth_legal(input int unsigned depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

  // Read latency must be one of the supported pipeline depths
  function automatic bit rd_lat_legal(input int unsigned lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// One read-output pipeline stage: registers data and valid, holds data while idle.
module ram_rd_pipe #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          valid_i,
  input  logic [DW-1:0] data_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o
);

  logic          valid_q;
  logic [DW-1:0] data_q;
  logic [DW-1:0] data_d;

  // Capture new data only when a read passes through; otherwise keep the last word
  always_comb begin
    data_d = data_q;
    if (valid_i) begin
      data_d = data_i;
    end
  end

  // Stage registers; reset clears both data and valid, discarding in-flight reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_i;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/dual_ram_be.sv
// Two-port RAM: instruction read port plus data read/write port with byte enables.
// Reads are sampled at the request edge and delivered through RD_LAT pipeline stages.
// Build option: define DUAL_RAM_FWD_EN to forward a same-edge data write into a
// colliding instruction read (write-first); otherwise the read sees the old word.
module dual_ram_be
  import dual_ram_pkg::*;
#(
  parameter int unsigned DW     = 32,
  parameter int unsigned DEPTH  = 65536,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ir_req_i,
  input  logic [AW-1:0]   ir_addr_i,
  output logic [DW-1:0]   ir_data_o,
  output logic            ir_valid_o,
  input  logic            d_req_i,
  input  logic            d_we_i,
  input  logic [DW/8-1:0] d_be_i,
  input  logic [AW-1:0]   d_addr_i,
  input  logic [DW-1:0]   d_wdata_i,
  output logic [DW-1:0]   d_rdata_o,
  output logic            d_valid_o
);

  localparam int unsigned BW = DW / 8;

  // Elaboration-time parameter checks
  if (!dw_legal(DW)) begin : g_bad_dw
    $error("dual_ram_be: DW must be a non-zero multiple of 8");
  end
  if (!depth_legal(DEPTH)) begin : g_bad_depth
    $error("dual_ram_be: DEPTH must be a power of two");
  end
  if (!rd_lat_legal(RD_LAT)) begin : g_bad_lat
    $error("dual_ram_be: RD_LAT must be 1 or 2");
  end

  // Storage array, deliberately not reset
  logic [DW-1:0] mem_q [DEPTH];

  logic          wr_en;
  logic          ir_rd_en;
  logic          d_rd_en;
  logic [BW-1:0] wr_be;
  logic [DW-1:0] wr_word_d;
  logic [DW-1:0] ir_word_d;
  logic [DW-1:0] d_word_d;

  // Per-port pipeline taps: index 0 is the array sample, index RD_LAT the output
  logic [DW-1:0] ir_stg_data [RD_LAT+1];
  logic          ir_stg_vld  [RD_LAT+1];
  logic [DW-1:0] d_stg_data  [RD_LAT+1];
  logic          d_stg_vld   [RD_LAT+1];

  // Request decode for the two ports
  always_comb begin
    wr_en    = d_req_i & d_we_i;
    d_rd_en  = d_req_i & ~d_we_i;
    ir_rd_en = ir_req_i;
    wr_be    = d_be_i;
  end

  // Merged word for the addressed location: enabled bytes new, others from the array
  always_comb begin
    wr_word_d = DW'(be_merge(BE_MAX_DW'(mem_q[d_addr_i]),
                             BE_MAX_DW'(d_wdata_i),
                             BE_MAX_BW'(wr_be)));
  end

  // Array write; a zero byte-enable rewrites the unchanged word
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[d_addr_i] <= wr_word_d;
    end
  end

  // Instruction read sample, optionally forwarding a colliding write
  always_comb begin
    ir_word_d = mem_q[ir_addr_i];
`ifdef DUAL_RAM_FWD_EN
    if (wr_en && (d_addr_i == ir_addr_i)) begin
      ir_word_d = wr_word_d;
    end
`endif
  end

  // Data read sample; the data port never reads and writes in the same cycle
  always_comb begin
    d_word_d = mem_q[d_addr_i];
  end

  assign ir_stg_data[0] = ir_word_d;
  assign ir_stg_vld[0]  = ir_rd_en;
  assign d_stg_data[0]  = d_word_d;
  assign d_stg_vld[0]   = d_rd_en;

  // Latency pipeline: one registered stage per cycle of read latency on each port
  for (genvar s = 0; s < RD_LAT; s++) begin : g_stage
    ram_rd_pipe #(
      .DW (DW)
    ) u_ir_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (ir_stg_vld[s]),
      .data_i  (ir_stg_data[s]),
      .valid_o (ir_stg_vld[s+1]),
      .data_o  (ir_stg_data[s+1])
    );

    ram_rd_pipe #(
      .DW (DW)
    ) u_d_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .valid_i (d_stg_vld[s]),
      .data_i  (d_stg_data[s]),
      .valid_o (d_stg_vld[s+1]),
      .data_o  (d_stg_data[s+1])
    );
  end

  assign ir_data_o  = ir_stg_data[RD_LAT];
  assign ir_valid_o = ir_stg_vld[RD_LAT];
  assign d_rdata_o  = d_stg_data[RD_LAT];
  assign d_valid_o  = d_stg_vld[RD_LAT];

endmodule

// File: tb/tb_dual_ram_be.sv
// Self-checking bench for dual_ram_be: directed scenarios plus random traffic,
// checked every cycle against a queue-based reference model.
module tb_dual_ram_be;

  localparam int unsigned DW     = 32;
  localparam int unsigned DEPTH  = 256;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned AW     = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            ir_req_i;
  logic [AW-1:0]   ir_addr_i;
  logic [DW-1:0]   ir_data_o;
  logic            ir_valid_o;
  logic            d_req_i;
  logic            d_we_i;
  logic [DW/8-1:0] d_be_i;
  logic [AW-1:0]   d_addr_i;
  logic [DW-1:0]   d_wdata_i;
  logic [DW-1:0]   d_rdata_o;
  logic            d_valid_o;

  always #5 clk = ~clk;

  dual_ram_be #(
    .DW     (DW),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ir_req_i   (ir_req_i),
    .ir_addr_i  (ir_addr_i),
    .ir_data_o  (ir_data_o),
    .ir_valid_o (ir_valid_o),
    .d_req_i    (d_req_i),
    .d_we_i     (d_we_i),
    .d_be_i     (d_be_i),
    .d_addr_i   (d_addr_i),
    .d_wdata_i  (d_wdata_i),
    .d_rdata_o  (d_rdata_o),
    .d_valid_o  (d_valid_o)
  );

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } pend_t;

  pend_t         irq[$];
  pend_t         dq[$];
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] ir_hold;
  logic [DW-1:0] d_hold;
  int            cyc;
  int            checks;
  int            failures;

  function automatic logic [31:0] merge_m(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = be[b] ? n[8*b +: 8] : o[8*b +: 8];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_idle();
    ir_req_i  = 1'b0;
    d_req_i   = 1'b0;
    d_we_i    = 1'b0;
    d_be_i    = '0;
  endtask

  task automatic set_wr(input logic [AW-1:0] a, input logic [DW-1:0] w, input logic [3:0] be);
    d_req_i   = 1'b1;
    d_we_i    = 1'b1;
    d_addr_i  = a;
    d_wdata_i = w;
    d_be_i    = be;
  endtask

  task automatic set_drd(input logic [AW-1:0] a);
    d_req_i  = 1'b1;
    d_we_i   = 1'b0;
    d_addr_i = a;
    d_be_i   = '0;
  endtask

  task automatic set_ird(input logic [AW-1:0] a);
    ir_req_i  = 1'b1;
    ir_addr_i = a;
  endtask

  // One clock: model what the DUT samples at the edge, then check outputs 1ns later
  task automatic cycle();
    pend_t p;
    bit    ev;
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      if (ir_req_i) begin
        p.due  = cyc + int'(RD_LAT) - 1;
        p.data = mem_m[ir_addr_i];
`ifdef DUAL_RAM_FWD_EN
        if (d_req_i && d_we_i && d_addr_i == ir_addr_i)
          p.data = merge_m(mem_m[ir_addr_i], d_wdata_i, d_be_i);
`endif
        irq.push_back(p);
      end
      if (d_req_i && !d_we_i) begin
        p.due  = cyc + int'(RD_LAT) - 1;
        p.data = mem_m[d_addr_i];
        dq.push_back(p);
      end
      if (d_req_i && d_we_i) mem_m[d_addr_i] = merge_m(mem_m[d_addr_i], d_wdata_i, d_be_i);
    end
    #1;
    ev = 1'b0;
    if (irq.size() > 0 && irq[0].due == cyc) begin
      ev = 1'b1;
      ir_hold = irq[0].data;
      void'(irq.pop_front());
    end
    chk("ir_valid", DW'(ir_valid_o), DW'(ev));
    chk("ir_data", ir_data_o, ir_hold);
    ev = 1'b0;
    if (dq.size() > 0 && dq[0].due == cyc) begin
      ev = 1'b1;
      d_hold = dq[0].data;
      void'(dq.pop_front());
    end
    chk("d_valid", DW'(d_valid_o), DW'(ev));
    chk("d_rdata", d_rdata_o, d_hold);
  endtask

  task automatic drain();
    set_idle();
    repeat (RD_LAT + 1) cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    ir_hold  = '0;
    d_hold   = '0;
    ir_addr_i = '0;
    d_addr_i  = '0;
    d_wdata_i = '0;
    set_idle();

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ir_data", ir_data_o, '0);
    chk("rst_ir_valid", DW'(ir_valid_o), '0);
    chk("rst_d_rdata", d_rdata_o, '0);
    chk("rst_d_valid", DW'(d_valid_o), '0);
    repeat (3) cycle();
    rst_n = 1'b1;

    // Fill the whole array so every later read has a defined expectation
    for (int a = 0; a < int'(DEPTH); a++) begin
      set_wr(AW'(a), $urandom, 4'hF);
      cycle();
    end
    set_idle();
    cycle();

    // Full write, read on both ports
    set_wr(AW'(5), 32'hDEADBEEF, 4'hF);
    cycle();
    set_idle();
    set_ird(AW'(5));
    set_drd(AW'(5));
    cycle();
    drain();
    chk("full_ir", ir_data_o, 32'hDEADBEEF);
    chk("full_d", d_rdata_o, 32'hDEADBEEF);

    // Partial write
    set_wr(AW'(7), 32'h11223344, 4'hF);
    cycle();
    set_wr(AW'(7), 32'hAABBCCDD, 4'b0101);
    cycle();
    set_drd(AW'(7));
    cycle();
    drain();
    chk("partial_d", d_rdata_o, 32'h11BB33DD);

    // Zero byte-enable write is a no-op
    set_wr(AW'(7), 32'hFFFFFFFF, 4'h0);
    cycle();
    set_ird(AW'(7));
    set_idle();
    set_ird(AW'(7));
    cycle();
    drain();
    chk("be0_ir", ir_data_o, 32'h11BB33DD);

    // Collision, then collision followed by an immediate read
    set_wr(AW'(9), 32'h0, 4'hF);
    cycle();
    set_wr(AW'(9), 32'h12345678, 4'hF);
    set_ird(AW'(9));
    cycle();
    drain();
`ifdef DUAL_RAM_FWD_EN
    chk("coll_ir", ir_data_o, 32'h12345678);
`else
    chk("coll_ir", ir_data_o, 32'h0);
`endif
    set_wr(AW'(9), 32'h0, 4'hF);
    cycle();
    set_wr(AW'(9), 32'h12345678, 4'hF);
    set_ird(AW'(9));
    cycle();
    set_idle();
    set_ird(AW'(9));
    set_drd(AW'(9));
    cycle();
    drain();
    chk("after_coll_ir", ir_data_o, 32'h12345678);
    chk("after_coll_d", d_rdata_o, 32'h12345678);

    // Streaming reads 0..15
    for (int a = 0; a < 16; a++) begin
      set_ird(AW'(a));
      cycle();
    end
    drain();
    chk("stream_hold", ir_data_o, mem_m[15]);
    chk("stream_valid_low", DW'(ir_valid_o), '0);

    // Top address
    set_wr(AW'(DEPTH - 1), 32'hCAFEF00D, 4'hF);
    cycle();
    set_idle();
    set_ird(AW'(DEPTH - 1));
    set_drd(AW'(DEPTH - 1));
    cycle();
    drain();
    chk("wrap_ir", ir_data_o, 32'hCAFEF00D);
    chk("wrap_d", d_rdata_o, 32'hCAFEF00D);

    // Reset one cycle after a request, before its data completes
    set_ird(AW'(5));
    set_drd(AW'(7));
    cycle();
    set_idle();
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_ir_data", ir_data_o, '0);
    chk("mid_rst_ir_valid", DW'(ir_valid_o), '0);
    chk("mid_rst_d_rdata", d_rdata_o, '0);
    chk("mid_rst_d_valid", DW'(d_valid_o), '0);
    irq.delete();
    dq.delete();
    ir_hold = '0;
    d_hold  = '0;
    repeat (2) cycle();
    rst_n = 1'b1;
    repeat (3) cycle();
    set_ird(AW'(5));
    set_drd(AW'(7));
    cycle();
    drain();
    chk("retain_ir", ir_data_o, 32'hDEADBEEF);
    chk("retain_d", d_rdata_o, 32'h11BB33DD);

    // Random traffic over a small address window to provoke collisions
    for (int i = 0; i < 400; i++) begin
      ir_req_i  = 1'($urandom_range(0, 1));
      ir_addr_i = AW'($urandom_range(0, 15));
      d_req_i   = 1'($urandom_range(0, 1));
      d_we_i    = 1'($urandom_range(0, 1));
      d_be_i    = 4'($urandom);
      d_addr_i  = AW'($urandom_range(0, 15));
      d_wdata_i = $urandom;
      cycle();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
